// File: rtl/if_imem_pkg.sv
// if_imem_pkg: shared types and widths for the IF instruction-memory responder
package if_imem_pkg;
    localparam int INSTR_W = 32;
    localparam int DEF_FETCH_WORDS = 8;
    typedef enum logic [1:0] {IDLE, BUSY, LOAD} imem_state_t;
    typedef logic [0:INSTR_W-1] instr_t;
    typedef instr_t instr_window_t [DEF_FETCH_WORDS];
endpackage

// File: rtl/imem_array.sv
// imem_array: instruction store with one write port and a wrapped multi-word combinational read
module imem_array import if_imem_pkg::*; #(
    parameter int DEPTH = 256,
    parameter int AW = 8,
    parameter int FETCH_WORDS = 8
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [AW-1:0]                  waddr,
    input  logic [INSTR_W-1:0]             wdata,
    input  logic [AW-1:0]                  raddr,
    output logic [FETCH_WORDS*INSTR_W-1:0] rdata
);
    logic [INSTR_W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    // AW-bit address arithmetic gives the modulo-DEPTH wrap for free
    for (genvar i = 0; i < FETCH_WORDS; i++) begin : g_rd
        assign rdata[i*INSTR_W +: INSTR_W] = mem[raddr + AW'(i)];
    end
endmodule

// File: rtl/if_imem_responder.sv
// if_imem_responder: answers IF fetches with a latency-delayed window and accepts loader writes
module if_imem_responder import if_imem_pkg::*; #(
    parameter int DEPTH = 256,
    parameter int AW = 8,
    parameter int FETCH_WORDS = 8,
    parameter int LATENCY = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           read_enable,
    input  logic [AW-1:0]                  pc,
    output logic                           stall,
    output logic [FETCH_WORDS*INSTR_W-1:0] instr,
    output logic                           instr_valid,
    input  logic                           ld_en,
    input  logic [AW-1:0]                  ld_addr,
    input  logic [INSTR_W-1:0]             ld_data,
    output logic                           ld_ready,
    output logic                           ld_done
);
    imem_state_t state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [FETCH_WORDS*INSTR_W-1:0] window_q, window_d, instr_q, instr_d, rd_window;
    logic valid_q, valid_d, done_q, done_d;

    assign ld_ready = state_q != BUSY;
    assign stall = read_enable & (state_q != IDLE | ld_en);
    assign instr = instr_q;
    assign instr_valid = valid_q;
    assign ld_done = done_q;

    imem_array #(.DEPTH(DEPTH), .AW(AW), .FETCH_WORDS(FETCH_WORDS)) u_array (
        .clk(clk),
        .we(ld_en & ld_ready),
        .waddr(ld_addr),
        .wdata(ld_data),
        .raddr(pc),
        .rdata(rd_window)
    );

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        window_d = window_q;
        instr_d = instr_q;
        valid_d = 1'b0;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld_en) state_d = LOAD;
                else if (read_enable) begin
                    window_d = rd_window;
                    cnt_d = 2'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 2'd0) begin
                    instr_d = window_q;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else cnt_d = cnt_q - 2'd1;
            end
            LOAD: begin
                if (!ld_en) begin
                    done_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            window_q <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            window_q <= window_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            done_q <= done_d;
        end
    end
endmodule
